dft_seq: RTL and testbench

DFT_SEQ -- requirements
Module: dft_seq

---
 rtl/dft_pkg.sv | 29 ++
 rtl/dft_seq_fifo.sv | 87 ++++++++
 rtl/dft_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_dft_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// -----------------------------------------------------------------------------
// dft_pkg
// Shared definitions for the DFT acquisition sequencer:
//   - default sample / result widths and chunk geometry
//   - FSM state type and encodings (IDLE -> FEED -> DRAIN -> DONE)
//   - counter width helper
// -----------------------------------------------------------------------------
package dft_pkg;

  localparam int DEF_DATA_W  = 12;   // ADC sample width
  localparam int DEF_OUT_W   = 15;   // DFT result width
  localparam int DEF_CHUNK_N = 32;   // samples per DFT chunk
  localparam int DEF_CHUNKS  = 256;  // chunks per acquisition
  localparam int DEF_FIFO_D  = 4;    // skid FIFO depth

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FEED  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Width of a counter that must be able to hold the value n itself
  // (not just 0..n-1).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dft_seq_fifo.sv
// -----------------------------------------------------------------------------
// dft_seq_fifo
// Small synchronous skid FIFO between the ADC and the DFT engine.
// Registered head: a word pushed into an empty FIFO is visible on rd_data
// (with empty=0) on the following cycle.
//
// A push while full is accepted only if a pop happens in the same cycle,
// so occupancy stays at DEPTH; otherwise the push is silently discarded and
// the caller is responsible for flagging the loss.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   flush      synchronous clear of pointers/occupancy
//   push       write wr_data
//   pop        consume head (ignored when empty)
//   wr_data    write data
//   rd_data    head of queue (valid when !empty)
//   full       occupancy == DEPTH
//   empty      occupancy == 0
// DEPTH must be a power of two, >= 2 (pointers wrap naturally).
// -----------------------------------------------------------------------------
module dft_seq_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; its contents are only
  // observed behind the occupancy count, which is reset, so a reset here would
  // only cost a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/dft_seq.sv
// -----------------------------------------------------------------------------
// dft_seq
// Acquisition sequencer: streams CHUNK_N*CHUNKS ADC samples through a skid
// FIFO into an external DFT engine and writes the CHUNKS results it returns
// into a result buffer.
//
// FSM: IDLE --start--> FEED --all samples pushed--> DRAIN
//      DRAIN --all results written && FIFO empty--> DONE --> IDLE
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (highest priority)
//   start           single-cycle start request, honoured only in IDLE
//   adc_data/valid  signed ADC sample stream (accepted only in FEED)
//   dft_data/valid  FIFO head towards the DFT; pop on dft_valid && dft_ready
//   dft_ready       DFT accepts the current sample
//   dft_res/valid   DFT results, one per high cycle (used in FEED and DRAIN)
//   res_addr/data/we  registered result-buffer write port
//   busy            high in FEED and DRAIN
//   done            one-cycle completion pulse
//   ovf             sticky: a sample was lost (FIFO overrun or watchdog)
//
// Optional feature (macro DFT_SEQ_TIMEOUT_EN): a 16-bit DRAIN watchdog that
// aborts the acquisition if dft_res_valid stays low for 65535 DRAIN cycles.
// Without the macro DRAIN waits indefinitely for the missing results.
// CHUNKS must be >= 2 so res_addr has at least one bit.
// -----------------------------------------------------------------------------
module dft_seq
  import dft_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int CHUNK_N = DEF_CHUNK_N,
  parameter int CHUNKS  = DEF_CHUNKS,
  parameter int FIFO_D  = DEF_FIFO_D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_W-1:0]         adc_data,
  input  logic                      adc_valid,
  output logic [DATA_W-1:0]         dft_data,
  output logic                      dft_valid,
  input  logic                      dft_ready,
  input  logic [OUT_W-1:0]          dft_res,
  input  logic                      dft_res_valid,
  output logic [$clog2(CHUNKS)-1:0] res_addr,
  output logic [OUT_W-1:0]          res_data,
  output logic                      res_we,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf
);

  localparam int ADDR_W = $clog2(CHUNKS);
  localparam int TOTAL  = CHUNK_N * CHUNKS;
  localparam int SCNT_W = cnt_w(TOTAL);
  localparam int RCNT_W = cnt_w(CHUNKS);

  state_t            state_q, state_d;
  logic [SCNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [RCNT_W-1:0] res_cnt_q, res_cnt_d;
  logic              ovf_q, ovf_d;
  logic              res_we_q, res_we_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [OUT_W-1:0]  res_data_q, res_data_d;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_flush;
  logic sample_drop, res_accept, res_all, wdog_hit;

  // ---------------------------------------------------------------------------
  // Skid FIFO
  // ---------------------------------------------------------------------------
  assign fifo_push  = (state_q == ST_FEED) && adc_valid;
  assign fifo_pop   = dft_valid && dft_ready;
  assign fifo_flush = wdog_hit;

  dft_seq_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (adc_data),
    .rd_data (dft_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dft_valid = !fifo_empty;

  // A full FIFO still takes the sample when the head leaves in the same cycle.
  assign sample_drop = fifo_push && fifo_full && !fifo_pop;

  // ---------------------------------------------------------------------------
  // Result capture: once CHUNKS results are written, further ones are ignored
  // so the address never wraps onto an earlier result.
  // ---------------------------------------------------------------------------
  assign res_all    = (res_cnt_q == RCNT_W'(CHUNKS));
  assign res_accept = ((state_q == ST_FEED) || (state_q == ST_DRAIN)) &&
                      dft_res_valid && !res_all;

  // ---------------------------------------------------------------------------
  // Optional DRAIN watchdog
  // ---------------------------------------------------------------------------
`ifdef DFT_SEQ_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if ((state_q != ST_DRAIN) || dft_res_valid) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  // Fires on the cycle the count steps onto 65535, so the abort lands
  // exactly 65535 result-less DRAIN cycles after entry.
  assign wdog_hit = (state_q == ST_DRAIN) && !dft_res_valid &&
                    (wdog_q == 16'hFFFE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    res_cnt_d    = res_cnt_q;
    ovf_d        = ovf_q;
    res_we_d     = 1'b0;
    res_addr_d   = res_addr_q;
    res_data_d   = res_data_q;

    if (res_accept) begin
      res_we_d   = 1'b1;
      res_addr_d = res_cnt_q[ADDR_W-1:0];
      res_data_d = dft_res;
      res_cnt_d  = res_cnt_q + RCNT_W'(1);
    end

    if (sample_drop) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_FEED;
          sample_cnt_d = '0;
          res_cnt_d    = '0;
          ovf_d        = 1'b0;
        end
      end
      ST_FEED: begin
        // Dropped samples are still counted, so the acquisition length is
        // fixed by the ADC stream rather than by DFT back-pressure.
        if (adc_valid) begin
          sample_cnt_d = sample_cnt_q + SCNT_W'(1);
          if (sample_cnt_q == SCNT_W'(TOTAL - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_all && fifo_empty) begin
          state_d = ST_DONE;
        end else if (wdog_hit) begin
          state_d = ST_DONE;
          ovf_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      res_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      res_we_q     <= 1'b0;
      res_addr_q   <= '0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      res_cnt_q    <= res_cnt_d;
      ovf_q        <= ovf_d;
      res_we_q     <= res_we_d;
      res_addr_q   <= res_addr_d;
      res_data_q   <= res_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign res_we   = res_we_q;
  assign res_addr = res_addr_q;
  assign res_data = res_data_q;
  assign busy     = (state_q == ST_FEED) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_dft_seq.sv
// -----------------------------------------------------------------------------
// tb_dft_seq
// Directed, table-driven bench for dft_seq with CHUNK_N=4, CHUNKS=3, FIFO_D=4
// (12 samples per acquisition). Inputs change 1 ns after a rising edge and
// outputs are sampled 1 ns after the next one, so every table row describes
// "inputs during cycle k" and "registered outputs after edge k".
// -----------------------------------------------------------------------------
module tb_dft_seq;

  localparam int DATA_W  = 12;
  localparam int OUT_W   = 15;
  localparam int CHUNK_N = 4;
  localparam int CHUNKS  = 3;
  localparam int FIFO_D  = 4;
  localparam int ADDR_W  = $clog2(CHUNKS);
  localparam int N_VEC   = 19;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic [DATA_W-1:0] dft_data;
  logic              dft_valid;
  logic              dft_ready;
  logic [OUT_W-1:0]  dft_res;
  logic              dft_res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [OUT_W-1:0]  res_data;
  logic              res_we;
  logic              busy;
  logic              done;
  logic              ovf;

  int n_cmp = 0;
  int n_err = 0;

  dft_seq #(
    .DATA_W  (DATA_W),
    .OUT_W   (OUT_W),
    .CHUNK_N (CHUNK_N),
    .CHUNKS  (CHUNKS),
    .FIFO_D  (FIFO_D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .dft_data      (dft_data),
    .dft_valid     (dft_valid),
    .dft_ready     (dft_ready),
    .dft_res       (dft_res),
    .dft_res_valid (dft_res_valid),
    .res_addr      (res_addr),
    .res_data      (res_data),
    .res_we        (res_we),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              start;
    logic              adc_valid;
    logic [DATA_W-1:0] adc_data;
    logic              dft_ready;
    logic              res_valid;
    logic [OUT_W-1:0]  res;
    logic              e_dft_valid;
    logic [DATA_W-1:0] e_dft_data;
    logic              e_res_we;
    logic [ADDR_W-1:0] e_res_addr;
    logic [OUT_W-1:0]  e_res_data;
    logic              e_busy;
    logic              e_done;
    logic              e_ovf;
  } vec_t;

  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start         = 1'b0;
    adc_valid     = 1'b0;
    adc_data      = '0;
    dft_ready     = 1'b1;
    dft_res_valid = 1'b0;
    dft_res       = '0;
  endtask

  // One clock: inputs already set, advance past the edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [DATA_W-1:0] d, input logic rdy);
    idle_inputs();
    adc_valid = 1'b1;
    adc_data  = d;
    dft_ready = rdy;
    step();
  endtask

  function automatic vec_t mk(
    input logic st, input logic av, input logic [DATA_W-1:0] ad,
    input logic rdy, input logic rv, input logic [OUT_W-1:0] rs,
    input logic e_dv, input logic [DATA_W-1:0] e_dd, input logic e_we,
    input logic [ADDR_W-1:0] e_ad, input logic [OUT_W-1:0] e_rd,
    input logic e_busy, input logic e_done, input logic e_ovf);
    vec_t v;
    v.start = st; v.adc_valid = av; v.adc_data = ad; v.dft_ready = rdy;
    v.res_valid = rv; v.res = rs;
    v.e_dft_valid = e_dv; v.e_dft_data = e_dd; v.e_res_we = e_we;
    v.e_res_addr = e_ad; v.e_res_data = e_rd;
    v.e_busy = e_busy; v.e_done = e_done; v.e_ovf = e_ovf;
    return v;
  endfunction

  initial begin
    logic [DATA_W-1:0] drain_exp [4];
    logic              saw_done;
    int                cycles;

    // ------------------------------------------------------------------
    // Main acquisition table: 12 samples with ready=1, start re-pulsed
    // mid-FEED (row 3), three results, done, then stray inputs in IDLE.
    // ------------------------------------------------------------------
    vecs[0] = mk(1, 0, '0, 1, 0, '0,    0, '0, 0, 2'd0, 15'h00, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      vecs[i] = mk(0, 1, DATA_W'(i), 1, 0, '0,
                   1, DATA_W'(i), 0, 2'd0, 15'h00, 1, 0, 0);
    end
    vecs[3].start = 1'b1;
    vecs[13] = mk(0, 0, '0, 1, 1, 15'h10, 0, '0, 1, 2'd0, 15'h10, 1, 0, 0);
    vecs[14] = mk(0, 0, '0, 1, 1, 15'h20, 0, '0, 1, 2'd1, 15'h20, 1, 0, 0);
    vecs[15] = mk(0, 0, '0, 1, 1, 15'h30, 0, '0, 1, 2'd2, 15'h30, 1, 0, 0);
    vecs[16] = mk(0, 0, '0, 1, 0, '0,     0, '0, 0, 2'd2, 15'h30, 0, 1, 0);
    vecs[17] = mk(0, 0, '0, 1, 0, '0,     0, '0, 0, 2'd2, 15'h30, 0, 0, 0);
    vecs[18] = mk(0, 1, 12'h0FF, 1, 1, 15'h55, 0, '0, 0, 2'd2, 15'h30, 0, 0, 0);

    // ------------------------------------------------------------------
    // Reset state
    // ------------------------------------------------------------------
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst_dft_valid", 32'(dft_valid), 32'd0);
    check("rst_res_we",    32'(res_we),    32'd0);
    check("rst_res_addr",  32'(res_addr),  32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < N_VEC; i++) begin
      start         = vecs[i].start;
      adc_valid     = vecs[i].adc_valid;
      adc_data      = vecs[i].adc_data;
      dft_ready     = vecs[i].dft_ready;
      dft_res_valid = vecs[i].res_valid;
      dft_res       = vecs[i].res;
      step();
      check($sformatf("v%0d_dft_valid", i), 32'(dft_valid), 32'(vecs[i].e_dft_valid));
      if (vecs[i].e_dft_valid)
        check($sformatf("v%0d_dft_data", i), 32'(dft_data), 32'(vecs[i].e_dft_data));
      check($sformatf("v%0d_res_we", i),   32'(res_we),   32'(vecs[i].e_res_we));
      check($sformatf("v%0d_res_addr", i), 32'(res_addr), 32'(vecs[i].e_res_addr));
      check($sformatf("v%0d_res_data", i), 32'(res_data), 32'(vecs[i].e_res_data));
      check($sformatf("v%0d_busy", i),     32'(busy),     32'(vecs[i].e_busy));
      check($sformatf("v%0d_done", i),     32'(done),     32'(vecs[i].e_done));
      check($sformatf("v%0d_ovf", i),      32'(ovf),      32'(vecs[i].e_ovf));
    end

    // ------------------------------------------------------------------
    // Back-pressure: 6 samples with ready=0 -> 4 held, 2 dropped, ovf.
    // Then a push+pop on a full FIFO must keep the new sample.
    // ------------------------------------------------------------------
    idle_inputs();
    start = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      push_sample(DATA_W'(12'h021 + i), 1'b0);
      check($sformatf("bp_ovf_%0d", i), 32'(ovf), (i >= 4) ? 32'd1 : 32'd0);
    end
    check("bp_dft_valid", 32'(dft_valid),        32'd1);
    check("bp_head",      32'(dft_data),         32'h021);
    check("bp_count",     32'(dut.sample_cnt_q), 32'd6);

    push_sample(12'h027, 1'b1);  // full FIFO, pop 0x021 and push 0x027
    check("full_pp_head",  32'(dft_data),         32'h022);
    check("full_pp_count", 32'(dut.sample_cnt_q), 32'd7);
    check("full_pp_ovf",   32'(ovf),              32'd1);

    drain_exp[0] = 12'h022;
    drain_exp[1] = 12'h023;
    drain_exp[2] = 12'h024;
    drain_exp[3] = 12'h027;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_valid_%0d", k), 32'(dft_valid), 32'd1);
      check($sformatf("drain_data_%0d", k),  32'(dft_data),  32'(drain_exp[k]));
      step();
    end
    check("drain_empty", 32'(dft_valid), 32'd0);

    // Finish the feed without results: DRAIN must keep waiting.
    for (int i = 0; i < 5; i++) push_sample(DATA_W'(12'h031 + i), 1'b1);
    idle_inputs();
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    check("drain_wait_busy", 32'(busy),     32'd1);
    check("drain_wait_done", 32'(saw_done), 32'd0);
    check("drain_wait_ovf",  32'(ovf),      32'd1);

    // ------------------------------------------------------------------
    // Reset mid-FEED with 3 samples queued; rst beats start and adc_valid.
    // ------------------------------------------------------------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) push_sample(DATA_W'(12'h041 + i), 1'b0);
    check("pre_rst_valid", 32'(dft_valid), 32'd1);
    check("pre_rst_busy",  32'(busy),      32'd1);
    rst       = 1'b1;
    start     = 1'b1;
    adc_valid = 1'b1;
    step();
    check("mid_rst_valid", 32'(dft_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_done",  32'(done),      32'd0);
    check("mid_rst_ovf",   32'(ovf),       32'd0);
    rst = 1'b0;
    idle_inputs();
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    check("post_rst_quiet", 32'(saw_done), 32'd0);

`ifdef DFT_SEQ_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Watchdog: full feed, no results -> abort 65535 cycles into DRAIN.
    // ------------------------------------------------------------------
    idle_inputs();
    start = 1'b1;
    step();
    for (int i = 0; i < 12; i++) push_sample(DATA_W'(i), 1'b1);
    idle_inputs();
    cycles = 0;
    while (!done && cycles < 70000) begin
      step();
      cycles++;
    end
    check("wdog_cycles", 32'(cycles), 32'd65535);
    check("wdog_done",   32'(done),   32'd1);
    check("wdog_ovf",    32'(ovf),    32'd1);
    check("wdog_empty",  32'(dft_valid), 32'd0);
    step();
    check("wdog_idle",   32'(busy | done), 32'd0);
`else
    cycles = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
